// File: rtl/uart_rx_timing.sv
// UART receive front end: line synchroniser, start-bit detect, oversampled baud base, mid-bit tick.
// Define UART_RX_MAJORITY_EN to take each bit decision from a 2-of-3 vote around the bit centre.
module uart_rx_timing #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd_async,
    output logic       rxd,
    output logic       tick,
    output logic [2:0] count,
    output logic       busy,
    output logic       frame_err
);
    localparam int DIV   = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = OVERSAMPLE / 2;
`else
    localparam int START_DEC = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_START = OS_W'(START_DEC);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_timing: CLK_FREQ_HZ/(BAUD*OVERSAMPLE) must be >= 2");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_timing: OVERSAMPLE must be even and >= 8");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       count_q, count_d;
    logic             tick_q, tick_d;
    logic             frame_err_q, frame_err_d;
    logic             os_tick;
    logic             dec_pt;
    logic             line_bit;

    assign os_tick = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    assign dec_pt  = os_tick &&
                     (((state_q == START) && (os_cnt_q == OS_START)) ||
                      (((state_q == DATA) || (state_q == STOP)) && (os_cnt_q == OS_LAST)));

`ifdef UART_RX_MAJORITY_EN
    // smp_q holds the two previous os-period samples; the current one is sync2_q.
    logic [1:0] smp_q, smp_d;
    logic       rxd_q, rxd_d;

    assign line_bit = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync2_q) | (smp_q[0] & sync2_q);
    assign rxd      = rxd_q;

    always_comb begin
        smp_d = smp_q;
        rxd_d = rxd_q;
        if (os_tick) smp_d = {smp_q[0], sync2_q};
        if (dec_pt)  rxd_d = line_bit;
    end
`else
    assign line_bit = sync2_q;
    assign rxd      = sync2_q;
`endif

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        count_d     = count_q;
        tick_d      = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE) begin
            div_cnt_d = '0;
            os_cnt_d  = '0;
        end else if (os_tick) begin
            div_cnt_d = '0;
            os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!sync2_q) state_d = START;
            end
            START: begin
                if (dec_pt) begin
                    if (!line_bit) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                        count_d   = 3'd0;
                        os_cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (dec_pt) begin
                    tick_d    = 1'b1;
                    count_d   = bit_idx_q;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
                // Leave DATA only after the bit-7 tick is visible, so tick never shows outside DATA.
                if (tick_q && (count_q == 3'd7)) state_d = STOP;
            end
            STOP: begin
                if (dec_pt) begin
                    frame_err_d = !line_bit;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_cnt_q   <= '0;
            os_cnt_q    <= '0;
            bit_idx_q   <= 3'd0;
            count_q     <= 3'd0;
            tick_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            smp_q       <= 2'b11;
            rxd_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= rxd_async;
            sync2_q     <= sync1_q;
            div_cnt_q   <= div_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_MAJORITY_EN
            smp_q       <= smp_d;
            rxd_q       <= rxd_d;
`endif
        end
    end

    assign tick      = tick_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_timing.sv
// Randomised frame-level bench for uart_rx_timing: expected (count, bit) per tick queued from the
// transmitted byte, popped and compared by a monitor whenever tick is seen.
module tb_uart_rx_timing;
  localparam int CLK_FREQ_HZ = 1_600_000;
  localparam int BAUD        = 10_000;
  localparam int OVERSAMPLE  = 16;
  localparam int BIT_CLKS    = CLK_FREQ_HZ / BAUD;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_EXP  = BIT_CLKS * 3 / 2 + 10;
  localparam int BUSY_EXP = BIT_CLKS * 19 / 2 + 10;
`else
  localparam int LAT_EXP  = BIT_CLKS * 3 / 2;
  localparam int BUSY_EXP = BIT_CLKS * 19 / 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd_async;
  logic       rxd;
  logic       tick;
  logic [2:0] count;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_timing #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD(BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rxd_async(rxd_async),
    .rxd(rxd),
    .tick(tick),
    .count(count),
    .busy(busy),
    .frame_err(frame_err)
  );

  // Entry = {bit index, expected line value at that tick}.
  logic [3:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int ticks_seen = 0;
  int err_seen = 0;
  int zeros_seen = 0;
  int fall_cyc = 0;
  int first_tick_cyc = 0;
  int busy_rise_cyc = 0;
  int busy_fall_cyc = 0;
  logic glitch_mode = 1'b0;
  logic abort_tx = 1'b0;

  int t0, e0, g0, n;
  logic [7:0] data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {rxd, tick, count, busy, frame_err}, 7'b1_0_000_0_0);
  endtask

  task automatic push_frame(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) exp_q.push_back({3'(i), d[i]});
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // One 10-bit frame, LSB first; optional 10-clk low pulse centred on each data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitch);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        if (abort_tx) begin
          rxd_async = 1'b1;
          return;
        end
        if (b == 0 && c == 0) fall_cyc = cyc;
        rxd_async = bits[b];
        if (glitch && b >= 1 && b <= 8 && c >= BIT_CLKS / 2 - 5 && c < BIT_CLKS / 2 + 5)
          rxd_async = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic prev_tick;
    logic prev_busy;
    logic [3:0] exp_v;
    prev_tick = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tick) begin
        ticks_seen++;
        if (count == 3'd0) first_tick_cyc = cyc;
        check("tick_gap", {31'd0, prev_tick}, 32'd0);
        check("busy_at_tick", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tick_unexpected: got count=%0d rxd=%0b expected no tick", count, rxd);
        end else begin
          exp_v = exp_q.pop_front();
          if (glitch_mode) begin
            check("tick_count", {29'd0, count}, {29'd0, exp_v[3:1]});
            if (!rxd) zeros_seen++;
          end else begin
            check("tick_data", {28'd0, count, rxd}, {28'd0, exp_v});
          end
        end
      end
      if (rst_n && frame_err) err_seen++;
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (!busy && prev_busy) busy_fall_cyc = cyc;
      prev_tick = tick;
      prev_busy = busy;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rxd_async = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk) rst_n = 1'b1;
    wait_cycles(20);

    // Reference frame 0xA5 with timing checks.
    t0 = ticks_seen; e0 = err_seen;
    push_frame(8'hA5, 8);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_cycles(100);
    check("a5_ticks", ticks_seen - t0, 8);
    check("a5_frame_err", err_seen - e0, 0);
    check_range("a5_first_tick_latency", first_tick_cyc - fall_cyc, LAT_EXP - 12, LAT_EXP + 12);
    check_range("a5_busy_drop", busy_fall_cyc - fall_cyc, BUSY_EXP - 24, BUSY_EXP + 24);
    check("a5_queue_empty", exp_q.size(), 0);

    // False start: 40-clk low pulse.
    t0 = ticks_seen;
    @(negedge clk);
    g0 = cyc;
    rxd_async = 1'b0;
    wait_cycles(40);
    rxd_async = 1'b1;
    wait_cycles(200);
    check("glitch_ticks", ticks_seen - t0, 0);
    check_range("glitch_busy_rise", busy_rise_cyc - g0, 1, 10);
    check_range("glitch_busy_len", busy_fall_cyc - busy_rise_cyc, 1, 99);
    check("glitch_idle", {31'd0, busy}, 32'd1 - 32'd1);

    // Random bytes with random idle gaps.
    t0 = ticks_seen; e0 = err_seen;
    for (int f = 0; f < 6; f++) begin
      data = 8'($urandom_range(0, 255));
      push_frame(data, 8);
      send_frame(data, 1'b1, 1'b0);
      wait_cycles($urandom_range(0, 60));
    end
    wait_cycles(100);
    check("rand_ticks", ticks_seen - t0, 48);
    check("rand_frame_err", err_seen - e0, 0);
    check("rand_queue_empty", exp_q.size(), 0);

    // Bad stop bit.
    t0 = ticks_seen; e0 = err_seen;
    push_frame(8'h00, 8);
    send_frame(8'h00, 1'b0, 1'b0);
    rxd_async = 1'b1;
    wait_cycles(400);
    check("badstop_ticks", ticks_seen - t0, 8);
    check("badstop_frame_err", err_seen - e0, 1);
    check("badstop_busy", {31'd0, busy}, 32'd0);
    check("badstop_queue_empty", exp_q.size(), 0);

    // Reset one clock after the third tick.
    t0 = ticks_seen;
    data = 8'($urandom_range(0, 255));
    push_frame(data, 3);
    abort_tx = 1'b0;
    fork
      send_frame(data, 1'b1, 1'b0);
      begin
        n = 0;
        for (int i = 0; i < 2000 && n < 3; i++) begin
          @(posedge clk);
          #1;
          if (tick) n++;
        end
        check("rst_third_tick_seen", n, 3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("reset_mid_frame");
        rst_n = 1'b1;
        abort_tx = 1'b1;
      end
    join
    abort_tx = 1'b0;
    wait_cycles(300);
    check("rst_ticks", ticks_seen - t0, 3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_queue_empty", exp_q.size(), 0);

    t0 = ticks_seen; e0 = err_seen;
    push_frame(8'h3C, 8);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_cycles(100);
    check("after_rst_ticks", ticks_seen - t0, 8);
    check("after_rst_frame_err", err_seen - e0, 0);
    check("after_rst_queue_empty", exp_q.size(), 0);

    // Back-to-back frames with no idle gap.
    t0 = ticks_seen; e0 = err_seen;
    push_frame(8'h55, 8);
    push_frame(8'hAA, 8);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0);
    wait_cycles(100);
    check("b2b_ticks", ticks_seen - t0, 16);
    check("b2b_frame_err", err_seen - e0, 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // 0xFF with a short low pulse at every data-bit centre.
    t0 = ticks_seen;
    zeros_seen = 0;
    glitch_mode = 1'b1;
    push_frame(8'hFF, 8);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_cycles(100);
    glitch_mode = 1'b0;
    check("vote_ticks", ticks_seen - t0, 8);
`ifdef UART_RX_MAJORITY_EN
    check("vote_zero_samples", zeros_seen, 0);
`else
    check_range("plain_zero_samples", zeros_seen, 1, 8);
`endif
    check("vote_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
